pp_buffer_param: RTL

Parametrised two-bank ping-pong buffer for the channel-coding chain, e.g. interleaver/deinterleaver staging.
- Write side fills one bank sequentially while the read side drains the other bank in a permuted order. The permutation comes from an external address generator driven by rd_idx.
- Adds configurable data width, depth and per-block length.
- Adds valid/ready back-pressure on both sides, 1-cycle registered read and an out-of-range read-address error flag.

---
 rtl/pp_buffer_param.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pp_buffer_param.sv
// Two-bank ping-pong buffer: one bank fills sequentially while the other drains
// in an externally permuted order, with valid/ready handshakes on both sides.
module pp_buffer_param #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 384,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] rd_idx,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic [1:0]        bank_full,
  output logic              err_addr
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  bank_state_t       state_q [2];
  bank_state_t       state_d [2];
  logic [ADDR_W:0]   len_q [2];
  logic [DATA_W-1:0] mem [2][DEPTH];

  logic              wr_sel;
  logic              rd_sel;
  logic [ADDR_W-1:0] wr_ptr;

  logic [ADDR_W:0]   eff_len;
  logic [ADDR_W:0]   wr_len;
  logic [ADDR_W:0]   rd_len;
  logic              accept;
  logic              wr_last;
  logic              rd_avail;
  logic              issue;
  logic              rd_last;
  logic              addr_bad;

  // Out-of-range lengths collapse to a full bank.
  assign eff_len  = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  assign wr_len   = (state_q[wr_sel] == EMPTY) ? eff_len : len_q[wr_sel];
  assign in_ready = (state_q[wr_sel] == EMPTY) || (state_q[wr_sel] == FILLING);
  assign accept   = in_valid && in_ready;
  assign wr_last  = ({1'b0, wr_ptr} == (wr_len - LEN_ONE));

  assign rd_len   = len_q[rd_sel];
  assign rd_avail = (state_q[rd_sel] == FULL) || (state_q[rd_sel] == DRAINING);
  assign issue    = rd_avail && (!out_valid || out_ready);
  assign rd_last  = ({1'b0, rd_idx} == (rd_len - LEN_ONE));
  assign addr_bad = ({1'b0, rd_addr} >= rd_len);

  assign bank_full[0] = (state_q[0] == FULL) || (state_q[0] == DRAINING);
  assign bank_full[1] = (state_q[1] == FULL) || (state_q[1] == DRAINING);

  // Write and read never touch the same bank in one cycle: their state sets are disjoint.
  always_comb begin
    state_d = state_q;
    if (accept)
      state_d[wr_sel] = wr_last ? FULL : FILLING;
    if (issue)
      state_d[rd_sel] = rd_last ? EMPTY : DRAINING;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept)
      mem[wr_sel][wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel   <= 1'b0;
      wr_ptr   <= '0;
      len_q[0] <= LEN_MAX;
      len_q[1] <= LEN_MAX;
    end else if (accept) begin
      if (state_q[wr_sel] == EMPTY)
        len_q[wr_sel] <= eff_len;
      if (wr_last) begin
        wr_ptr <= '0;
        wr_sel <= ~wr_sel;
      end else begin
        wr_ptr <= wr_ptr + IDX_ONE;
      end
    end
  end

  // Registered read port; the held word stays stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sel    <= 1'b0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err_addr  <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_data  <= addr_bad ? '0 : mem[rd_sel][rd_addr];
      out_last  <= rd_last;
      if (addr_bad)
        err_addr <= 1'b1;
      if (rd_last) begin
        rd_idx <= '0;
        rd_sel <= ~rd_sel;
      end else begin
        rd_idx <= rd_idx + IDX_ONE;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
